// File: rtl/snn_pkg.sv
// snn_pkg: readout geometry, derived widths and readout FSM states
package snn_pkg;
  localparam int ADDR_W   = 9;
  localparam int OUT_BASE = 64;
  localparam int N_OUT    = 64;
  localparam int CNT_W    = 8;
  localparam int T_STEPS  = 129;
  localparam int IDX_W    = $clog2(N_OUT);
  localparam int STEP_W   = $clog2(T_STEPS + 1);
  typedef enum logic [1:0] {ACCUM, SCAN, HOLD} rd_state_e;
endpackage

// File: rtl/spk_readout_unit_if.sv
// spk_readout_unit_if: spike-write snoop, step pulse and result handshake
interface spk_readout_unit_if import snn_pkg::*; ();
   logic              spk_write_we;
   logic [ADDR_W-1:0] spk_write_addr;
   logic              spk_write_data;
   logic              step_done;
   logic              result_valid;
   logic              result_ready;
   logic [IDX_W-1:0]  result_class;
   logic [CNT_W-1:0]  result_count;
   logic              busy;
   logic              overrun;
   modport master (output spk_write_we, spk_write_addr, spk_write_data, step_done, result_ready,
                   input  result_valid, result_class, result_count, busy, overrun);
   modport slave  (input  spk_write_we, spk_write_addr, spk_write_data, step_done, result_ready,
                   output result_valid, result_class, result_count, busy, overrun);
endinterface

// File: rtl/spk_argmax_scan.sv
// spk_argmax_scan: one-compare-per-cycle argmax; start seeds best so ties keep the lowest index
module spk_argmax_scan import snn_pkg::*; (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             start,
   input  logic [IDX_W-1:0] idx,
   input  logic [CNT_W-1:0] value,
   output logic [IDX_W-1:0] best_idx,
   output logic [CNT_W-1:0] best_val,
   output logic             done
);
   assign done = en && idx == IDX_W'(N_OUT - 1);
   always_ff @(posedge clk) begin
      if (reset) begin
         best_idx <= '0;
         best_val <= '0;
      end else if (en && (start || value > best_val)) begin
         best_idx <= idx;
         best_val <= value;
      end
   end
endmodule

// File: rtl/spk_readout_unit.sv
// spk_readout_unit: counts output-layer spikes over a frame, then offers the argmax class to the host
module spk_readout_unit import snn_pkg::*; (
   input  logic clk,
   input  logic reset,
   spk_readout_unit_if.slave bus
);
   rd_state_e         state, state_nx;
   logic [CNT_W-1:0]  cnt [N_OUT];
   logic [STEP_W-1:0] step_cnt;
   logic [IDX_W-1:0]  scan_idx;
   logic [ADDR_W-1:0] off;
   logic              hit, hs, last_step, scan_done, overrun_q;
   assign off       = bus.spk_write_addr - ADDR_W'(OUT_BASE);
   assign hit       = bus.spk_write_we && bus.spk_write_data &&
                      bus.spk_write_addr >= ADDR_W'(OUT_BASE) && off < ADDR_W'(N_OUT);
   assign hs        = state == HOLD && bus.result_ready;
   assign last_step = bus.step_done && step_cnt == STEP_W'(T_STEPS - 1);
   always_comb begin
      state_nx = state;
      state_nx = (state == ACCUM && last_step) ? SCAN :
                 (state == SCAN && scan_done)  ? HOLD :
                 hs                            ? ACCUM : state;
   end
   always_ff @(posedge clk) begin
      if (reset) state <= ACCUM;
      else       state <= state_nx;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt       <= '{default: '0};
         step_cnt  <= '0;
         scan_idx  <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (hs) begin
            cnt      <= '{default: '0};
            step_cnt <= '0;
         end else if (state == ACCUM) begin
            if (hit && cnt[off[IDX_W-1:0]] != '1) cnt[off[IDX_W-1:0]] <= cnt[off[IDX_W-1:0]] + 1'b1;
            if (bus.step_done) step_cnt <= step_cnt + 1'b1;
         end
         // wraps back to 0 after the last index, so every scan starts at 0
         scan_idx <= state == SCAN ? scan_idx + 1'b1 : '0;
         if (state != ACCUM && hit) overrun_q <= 1'b1;
      end
   end
   spk_argmax_scan u_scan (
      .clk      (clk),
      .reset    (reset),
      .en       (state == SCAN),
      .start    (scan_idx == '0),
      .idx      (scan_idx),
      .value    (cnt[scan_idx]),
      .best_idx (bus.result_class),
      .best_val (bus.result_count),
      .done     (scan_done)
   );
   assign bus.result_valid = state == HOLD;
   assign bus.busy         = state != ACCUM;
   assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_spk_readout_unit.sv
// tb_spk_readout_unit: directed frames with hand-computed argmax results
module tb_spk_readout_unit;
   import snn_pkg::*;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   lat;
   spk_readout_unit_if bus ();
   spk_readout_unit dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input logic we, input int a, input logic d, input logic s);
      @(negedge clk);
      bus.spk_write_we   = we;
      bus.spk_write_addr = ADDR_W'(a);
      bus.spk_write_data = d;
      bus.step_done      = s;
   endtask

   task automatic idle();
      cyc(1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic wr(input int a, input logic d, input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, a, d, 1'b0);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 1'b1);
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (bus.result_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("valid_timeout", {31'b0, bus.result_valid}, 32'd1);
   endtask

   task automatic handshake();
      @(negedge clk);
      bus.result_ready = 1'b1;
      @(negedge clk);
      bus.result_ready = 1'b0;
      chk("hs_valid", {31'b0, bus.result_valid}, 32'd0);
      chk("hs_busy", {31'b0, bus.busy}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      bus.spk_write_we = 1'b0;
      bus.spk_write_addr = '0;
      bus.spk_write_data = 1'b0;
      bus.step_done = 1'b0;
      bus.result_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_valid", {31'b0, bus.result_valid}, 32'd0);
      chk("rst_class", 32'(bus.result_class), 32'd0);
      chk("rst_count", 32'(bus.result_count), 32'd0);
      chk("rst_busy", {31'b0, bus.busy}, 32'd0);
      chk("rst_overrun", {31'b0, bus.overrun}, 32'd0);
      // frame 1: three hits on neuron 6; out-of-window and data=0 writes ignored
      bus.result_ready = 1'b1;
      wr(70, 1'b1, 3);
      wr(63, 1'b1, 5);
      wr(128, 1'b1, 5);
      wr(70, 1'b0, 5);
      cyc(1'b0, 70, 1'b1, 1'b0);
      idle();
      bus.result_ready = 1'b0;
      steps(T_STEPS);
      idle();
      chk("scan_busy", {31'b0, bus.busy}, 32'd1);
      wait_valid(lat);
      chk("scan_latency", 32'(lat), 32'd64);
      chk("f1_class", 32'(bus.result_class), 32'd6);
      chk("f1_count", 32'(bus.result_count), 32'd3);
      handshake();
      // frame 2: nothing written, counters must have been cleared
      steps(T_STEPS);
      idle();
      wait_valid(lat);
      chk("f2_class", 32'(bus.result_class), 32'd0);
      chk("f2_count", 32'(bus.result_count), 32'd0);
      handshake();
      // frame 3: tie 5/9 at 4, last write to 5 coincides with final step
      wr(69, 1'b1, 3);
      wr(73, 1'b1, 4);
      wr(66, 1'b1, 3);
      steps(T_STEPS - 1);
      cyc(1'b1, 69, 1'b1, 1'b1);
      idle();
      wr(100, 1'b1, 10);
      idle();
      chk("overrun_set", {31'b0, bus.overrun}, 32'd1);
      wait_valid(lat);
      chk("f3_class", 32'(bus.result_class), 32'd5);
      chk("f3_count", 32'(bus.result_count), 32'd4);
      repeat (20) idle();
      chk("hold_valid", {31'b0, bus.result_valid}, 32'd1);
      chk("hold_class", 32'(bus.result_class), 32'd5);
      chk("hold_count", 32'(bus.result_count), 32'd4);
      handshake();
      chk("overrun_sticky", {31'b0, bus.overrun}, 32'd1);
      // frame 4: saturation
      wr(64, 1'b1, 300);
      steps(T_STEPS);
      idle();
      wait_valid(lat);
      chk("sat_class", 32'(bus.result_class), 32'd0);
      chk("sat_count", 32'(bus.result_count), 32'd255);
      handshake();
      // frame 5: reset mid-scan, then a fresh frame must not see the old counts
      wr(80, 1'b1, 5);
      steps(T_STEPS);
      idle();
      repeat (10) idle();
      chk("mid_busy", {31'b0, bus.busy}, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mrst_valid", {31'b0, bus.result_valid}, 32'd0);
      chk("mrst_busy", {31'b0, bus.busy}, 32'd0);
      chk("mrst_overrun", {31'b0, bus.overrun}, 32'd0);
      chk("mrst_class", 32'(bus.result_class), 32'd0);
      chk("mrst_count", 32'(bus.result_count), 32'd0);
      wr(70, 1'b1, 2);
      steps(T_STEPS);
      idle();
      wait_valid(lat);
      chk("f6_class", 32'(bus.result_class), 32'd6);
      chk("f6_count", 32'(bus.result_count), 32'd2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
